// File: rtl/ram_loader_pkg.sv
// Shared constants for the boot-time RAM loader: default widths and FSM encoding.
package ram_loader_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 16;
    localparam int BYTE_W     = 8;
    localparam int STATE_W    = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOAD   = 3'd1;
    localparam logic [STATE_W-1:0] ST_CKSUM  = 3'd2;
    localparam logic [STATE_W-1:0] ST_VERIFY = 3'd3;
    localparam logic [STATE_W-1:0] ST_CHECK  = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE   = 3'd5;
    localparam logic [STATE_W-1:0] ST_ERROR  = 3'd6;

endpackage

// File: rtl/ram_loader_byte_packer.sv
// Packs a big-endian byte stream into 16-bit words. word/word_valid are
// combinational and valid in the cycle the low byte arrives, so the caller
// can register the write for the following cycle.
module ram_loader_byte_packer
    import ram_loader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic [BYTE_W-1:0]   rx_data,
    input  logic                rx_valid,
    output logic [2*BYTE_W-1:0] word,
    output logic                word_valid
);

    logic              phase_q;
    logic              phase_d;
    logic [BYTE_W-1:0] hi_q;
    logic [BYTE_W-1:0] hi_d;

    assign word       = {hi_q, rx_data};
    assign word_valid = rx_valid && phase_q && !clear;

    // Next phase / high byte: clear drops any half-received word.
    always_comb begin
        phase_d = phase_q;
        hi_d    = hi_q;
        if (clear) begin
            phase_d = 1'b0;
        end else if (rx_valid) begin
            if (!phase_q) begin
                hi_d    = rx_data;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
            end
        end
    end

    // Phase flag and latched high byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= 1'b0;
            hi_q    <= '0;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
        end
    end

endmodule

// File: rtl/ram_loader.sv
// Boot loader: writes a UART-delivered image into RAM port 1, reads it back,
// checks both sums against the host checksum, and releases the cores on success.
// RAM strobes are registered so they are valid for the whole cycle the RAM samples.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int WORD_COUNT = 512,
    parameter int BASE_ADDR  = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [BYTE_W-1:0]  rx_data,
    input  logic               rx_valid,
    input  logic [DATA_W-1:0]  ram_data_out,
    output logic               write_en,
    output logic               read_en,
    output logic [ADDR_W-1:0]  addr,
    output logic [DATA_W-1:0]  Data_in,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               cores_hold,
    output logic [STATE_W-1:0] dbg_state
);

    localparam int                CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  WC      = CNT_W'(WORD_COUNT);
    localparam logic [CNT_W-1:0]  WC_LAST = CNT_W'(WORD_COUNT - 1);
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  wsum_q, wsum_d;
    logic [DATA_W-1:0]  rsum_q, rsum_d;
    logic [DATA_W-1:0]  cksum_q, cksum_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               write_en_q, write_en_d;
    logic               read_en_q, read_en_d;
    logic               rvalid_q, rvalid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               hold_q, hold_d;

    logic               packer_clear;
    logic [DATA_W-1:0]  word;
    logic               word_valid;

    // Bytes are only framed while an image is being received.
    assign packer_clear = !((state_q == ST_LOAD) || (state_q == ST_CKSUM));

    ram_loader_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (packer_clear),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .word       (word),
        .word_valid (word_valid)
    );

    assign write_en   = write_en_q;
    assign read_en    = read_en_q;
    assign addr       = addr_q;
    assign Data_in    = data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign cores_hold = hold_q;
    assign dbg_state  = state_q;

    // FSM, counter, sums and RAM port next-state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wsum_d     = wsum_q;
        rsum_d     = rsum_q;
        cksum_d    = cksum_q;
        addr_d     = addr_q;
        data_d     = data_q;
        write_en_d = 1'b0;
        read_en_d  = 1'b0;
        rvalid_d   = read_en_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        hold_d     = hold_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    wsum_d  = '0;
                    rsum_d  = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    hold_d  = 1'b1;
                end
            end
            ST_LOAD: begin
                if (word_valid) begin
                    write_en_d = 1'b1;
                    addr_d     = BASE_A + cnt_q[ADDR_W-1:0];
                    data_d     = word;
                    wsum_d     = wsum_q + word;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == WC_LAST) begin
                        state_d = ST_CKSUM;
                    end
                end
            end
            ST_CKSUM: begin
                if (word_valid) begin
                    cksum_d = word;
                    cnt_d   = '0;
                    state_d = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (cnt_q != WC) begin
                    read_en_d = 1'b1;
                    addr_d    = BASE_A + cnt_q[ADDR_W-1:0];
                    cnt_d     = cnt_q + 1'b1;
                end
                if (rvalid_q) begin
                    rsum_d = rsum_q + ram_data_out;
                end
                // Last read data is on the bus: no read in flight, all issued.
                if (rvalid_q && !read_en_q && (cnt_q == WC)) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                busy_d = 1'b0;
                if ((wsum_q == cksum_q) && (rsum_q == cksum_q)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                end else begin
                    state_d = ST_ERROR;
                    error_d = 1'b1;
                    hold_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset returns everything to idle with cores held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            wsum_q     <= '0;
            rsum_q     <= '0;
            cksum_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            write_en_q <= 1'b0;
            read_en_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            hold_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wsum_q     <= wsum_d;
            rsum_q     <= rsum_d;
            cksum_q    <= cksum_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            write_en_q <= write_en_d;
            read_en_q  <= read_en_d;
            rvalid_q   <= rvalid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            hold_q     <= hold_d;
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader with a 4-word image: behavioural RAM, expected
// write/read queues, and a checksum model computed from the word list.
module tb_ram_loader;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
    localparam int WC     = 4;
    localparam int BASE   = 0;

    logic              clk;
    logic              reset;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] ram_data_out;
    logic              write_en;
    logic              read_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] Data_in;
    logic              busy;
    logic              done;
    logic              error;
    logic              cores_hold;
    logic [2:0]        dbg_state;

    int total;
    int bad;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0]        exp_rd_q[$];
    logic [DATA_W-1:0]        mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0]        img [WC];

    ram_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORD_COUNT(WC), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .rx_data(rx_data),
        .rx_valid(rx_valid), .ram_data_out(ram_data_out), .write_en(write_en),
        .read_en(read_en), .addr(addr), .Data_in(Data_in), .busy(busy),
        .done(done), .error(error), .cores_hold(cores_hold), .dbg_state(dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: one-cycle read latency
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        ram_data_out = '0;
    end
    always @(posedge clk) begin
        if (write_en) mem[addr] <= Data_in;
        if (read_en) ram_data_out <= mem[addr];
    end

    // Scoreboard: every write/read strobe must match the next expected entry
    always @(negedge clk) begin
        if (!reset) begin
            if (write_en && read_en) begin
                total++; bad++;
                $display("FAIL rw_overlap got write_en=1 read_en=1 exp one at most");
            end
            if (write_en) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write got addr=%h data=%h exp none", addr, Data_in);
                end else begin
                    logic [ADDR_W+DATA_W-1:0] e;
                    e = exp_q.pop_front();
                    if ({addr, Data_in} !== e) begin
                        bad++;
                        $display("FAIL write got addr=%h data=%h exp addr=%h data=%h",
                                 addr, Data_in, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
                    end
                end
            end
            if (read_en) begin
                total++;
                if (exp_rd_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_read got addr=%h exp none", addr);
                end else begin
                    logic [ADDR_W-1:0] ea;
                    ea = exp_rd_q.pop_front();
                    if (addr !== ea) begin
                        bad++;
                        $display("FAIL read_addr got %h exp %h", addr, ea);
                    end
                end
            end
        end
    end

    // Image is accepted only if the word sum mod 2**16 equals the checksum
    function automatic logic model_ok(input logic [DATA_W-1:0] w[WC], input logic [DATA_W-1:0] ck);
        int s;
        s = 0;
        for (int i = 0; i < WC; i++) s = s + int'(w[i]);
        return (s % 65536) == int'(ck);
    endfunction

    function automatic logic [DATA_W-1:0] model_sum(input logic [DATA_W-1:0] w[WC]);
        int s;
        s = 0;
        for (int i = 0; i < WC; i++) s = s + int'(w[i]);
        return DATA_W'(s % 65536);
    endfunction

    // Drivers (called at a negedge, return at a negedge)
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_image(input logic [DATA_W-1:0] w[WC], input logic [DATA_W-1:0] ck,
                              input int max_gap);
        for (int i = 0; i < WC; i++) begin
            exp_q.push_back({ADDR_W'((BASE + i) % (1 << ADDR_W)), w[i]});
            exp_rd_q.push_back(ADDR_W'((BASE + i) % (1 << ADDR_W)));
        end
        for (int i = 0; i < WC; i++) begin
            send_byte(w[i][15:8], $urandom_range(max_gap, 0));
            send_byte(w[i][7:0], $urandom_range(max_gap, 0));
        end
        send_byte(ck[15:8], $urandom_range(max_gap, 0));
        send_byte(ck[7:0], $urandom_range(max_gap, 0));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL %s_timeout got busy=1 exp busy=0 within 300 cycles", tag);
        end
        total++;
        if (exp_q.size() != 0 || exp_rd_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing got pending writes=%0d reads=%0d exp 0", tag,
                     exp_q.size(), exp_rd_q.size());
        end
    endtask

    task automatic check_result(input string tag, input logic exp_done);
        total++;
        if ({done, error, cores_hold} !== {exp_done, !exp_done, !exp_done}) begin
            bad++;
            $display("FAIL %s_result got done=%b error=%b hold=%b exp done=%b error=%b hold=%b",
                     tag, done, error, cores_hold, exp_done, !exp_done, !exp_done);
        end
    endtask

    task automatic run_image(input string tag, input logic [DATA_W-1:0] w[WC],
                             input logic [DATA_W-1:0] ck, input int max_gap);
        pulse_start();
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            bad++;
            $display("FAIL %s_start got busy=%b done=%b error=%b exp 1 0 0", tag, busy, done, error);
        end
        send_image(w, ck, max_gap);
        wait_idle(tag);
        check_result(tag, model_ok(w, ck));
    endtask

    // Tests
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({write_en, read_en, addr, Data_in} !== '0) begin
            bad++;
            $display("FAIL reset_port got we=%b re=%b addr=%h din=%h exp zeros", write_en, read_en, addr, Data_in);
        end
        total++;
        if ({busy, done, error, cores_hold} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_status got %b exp 0001", {busy, done, error, cores_hold});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        img = '{16'h0001, 16'h0007, 16'h000F, 16'h0046};
        run_image("basic", img, model_sum(img), 3);
        // done is sticky and bytes in DONE are ignored (monitor rejects writes)
        send_byte(8'h12, 0);
        send_byte(8'h34, 2);
        total++;
        if (done !== 1'b1 || cores_hold !== 1'b0) begin
            bad++;
            $display("FAIL sticky_done got done=%b hold=%b exp 1 0", done, cores_hold);
        end
    endtask

    task automatic test_bad_cksum();
        img = '{16'h0001, 16'h0007, 16'h000F, 16'h0046};
        run_image("bad_cksum", img, model_sum(img) + 16'd1, 1);
        run_image("recover", img, model_sum(img), 1);
    endtask

    task automatic test_wrap();
        img = '{16'hFFFF, 16'h0002, 16'h0000, 16'h0000};
        run_image("wrap", img, 16'h0001, 2);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < WC; i++) img[i] = 16'($urandom);
        run_image("b2b", img, model_sum(img), 0);
    endtask

    task automatic test_reset_mid();
        pulse_start();
        exp_q.push_back({ADDR_W'(BASE), 16'h0011});
        exp_q.push_back({ADDR_W'(BASE + 1), 16'h2233});
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);   // arrives while the second write is on the port
        #2 reset = 1'b1;
        #1;
        total++;
        if ({write_en, read_en, addr, Data_in} !== '0 || {busy, done, error, cores_hold} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_mid got we=%b re=%b addr=%h din=%h bdeh=%b exp zeros 0001",
                     write_en, read_en, addr, Data_in, {busy, done, error, cores_hold});
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL reset_mid_writes got pending=%0d exp 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < WC; i++) img[i] = 16'($urandom);
        run_image("after_reset", img, model_sum(img), 1);
    endtask

    task automatic test_start_during_load();
        for (int i = 0; i < WC; i++) begin
            img[i] = 16'($urandom);
            exp_q.push_back({ADDR_W'(BASE + i), img[i]});
            exp_rd_q.push_back(ADDR_W'(BASE + i));
        end
        pulse_start();
        send_byte(img[0][15:8], 0);
        send_byte(img[0][7:0], 0);
        send_byte(img[1][15:8], 0);
        pulse_start();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL restart_busy got %b exp 1", busy);
        end
        send_byte(img[1][7:0], 1);
        for (int i = 2; i < WC; i++) begin
            send_byte(img[i][15:8], 0);
            send_byte(img[i][7:0], 0);
        end
        send_byte(model_sum(img) >> 8, 0);
        send_byte(model_sum(img) & 16'hFF, 0);
        wait_idle("restart");
        check_result("restart", 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            logic [DATA_W-1:0] ck;
            for (int i = 0; i < WC; i++) img[i] = 16'($urandom);
            ck = model_sum(img);
            if ($urandom_range(1, 0) == 0) ck = ck + 16'($urandom_range(65535, 1));
            run_image("random", img, ck, 2);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_bad_cksum();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_start_during_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
